// File: rtl/ip_tx_arbiter.sv
// Round-robin arbiter sharing the IP transmit path between ICMP and UDP sources.
// Latency: grant 1 cycle after req is sampled; data forwarded through one register stage.
// Backpressure: i_ip_busy holds off new selections in IDLE; a stalled granted source is aborted by the watchdog.
module ip_tx_arbiter #(
  parameter int         GAP_CYCLES = 12,
  parameter int         TIMEOUT    = 4096,
  parameter logic [7:0] PROTO_ICMP = 8'd1,
  parameter logic [7:0] PROTO_UDP  = 8'd17
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_icmp_req,
  input  logic [15:0] i_icmp_len,
  input  logic [7:0]  i_icmp_data,
  input  logic        i_icmp_last,
  input  logic        i_icmp_valid,
  output logic        o_icmp_grant,
  input  logic        i_udp_req,
  input  logic [15:0] i_udp_len,
  input  logic [7:0]  i_udp_data,
  input  logic        i_udp_last,
  input  logic        i_udp_valid,
  output logic        o_udp_grant,
  input  logic        i_ip_busy,
  output logic [15:0] o_ip_len,
  output logic [7:0]  o_ip_proto,
  output logic [7:0]  o_ip_data,
  output logic        o_ip_last,
  output logic        o_ip_valid,
  output logic        o_timeout
);

  localparam int WW = $clog2(TIMEOUT);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, XFER, GAP} state_e;

  state_e        state_q;
  logic          ptr_q;        // 1: UDP preferred on a tie, 0: ICMP preferred
  logic          sel_q;        // 1: UDP owns the path, 0: ICMP
  logic          grant_icmp_q;
  logic          grant_udp_q;
  logic [15:0]   len_q;
  logic [7:0]    proto_q;
  logic [7:0]    data_q;
  logic          last_q;
  logic          valid_q;
  logic          timeout_q;
  logic [WW-1:0] wd_q;
  logic [GW-1:0] gap_q;

  logic       src_valid;
  logic       src_last;
  logic [7:0] src_data;
  logic       any_req;
  logic       pick_udp;

  // Mux the owning source's stream and resolve the winner among pending requests
  always_comb begin
    src_valid = sel_q ? i_udp_valid : i_icmp_valid;
    src_last  = sel_q ? i_udp_last  : i_icmp_last;
    src_data  = sel_q ? i_udp_data  : i_icmp_data;
    any_req   = i_icmp_req | i_udp_req;
    pick_udp  = (i_icmp_req & i_udp_req) ? ptr_q : i_udp_req;
  end

  // Arbitration FSM with registered grants, forwarding stage, watchdog and gap timer
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q      <= IDLE;
      ptr_q        <= 1'b0;
      sel_q        <= 1'b0;
      grant_icmp_q <= 1'b0;
      grant_udp_q  <= 1'b0;
      len_q        <= '0;
      proto_q      <= '0;
      data_q       <= '0;
      last_q       <= 1'b0;
      valid_q      <= 1'b0;
      timeout_q    <= 1'b0;
      wd_q         <= '0;
      gap_q        <= '0;
    end else begin
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!i_ip_busy && any_req) begin
            sel_q        <= pick_udp;
            ptr_q        <= ~pick_udp;
            grant_icmp_q <= ~pick_udp;
            grant_udp_q  <= pick_udp;
            len_q        <= pick_udp ? i_udp_len : i_icmp_len;
            proto_q      <= pick_udp ? PROTO_UDP : PROTO_ICMP;
            wd_q         <= '0;
            state_q      <= XFER;
          end
        end
        XFER: begin
          if (src_valid) begin
            valid_q <= 1'b1;
            data_q  <= src_data;
            last_q  <= src_last;
            wd_q    <= '0;
            if (src_last) begin
              grant_icmp_q <= 1'b0;
              grant_udp_q  <= 1'b0;
              gap_q        <= '0;
              state_q      <= (GAP_CYCLES == 0) ? IDLE : GAP;
            end
          end else if (wd_q == WD_LAST) begin
            // Stalled source: abort without a synthetic last
            timeout_q    <= 1'b1;
            grant_icmp_q <= 1'b0;
            grant_udp_q  <= 1'b0;
            gap_q        <= '0;
            state_q      <= (GAP_CYCLES == 0) ? IDLE : GAP;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        GAP: begin
          if (gap_q == GAP_LAST) begin
            state_q <= IDLE;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_icmp_grant = grant_icmp_q;
  assign o_udp_grant  = grant_udp_q;
  assign o_ip_len     = len_q;
  assign o_ip_proto   = proto_q;
  assign o_ip_data    = data_q;
  assign o_ip_last    = last_q;
  assign o_ip_valid   = valid_q;
  assign o_timeout    = timeout_q;

endmodule

// File: tb/tb_ip_tx_arbiter.sv
// Directed bench for ip_tx_arbiter with GAP_CYCLES=12 and TIMEOUT=16.
// Inputs are driven 1 ns after the rising edge; outputs are sampled at the same point.
// Expected values are hand-derived from the arbiter's timing rules.
module tb_ip_tx_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_icmp_req = 1'b0;
  logic [15:0] i_icmp_len = '0;
  logic [7:0]  i_icmp_data = '0;
  logic        i_icmp_last = 1'b0;
  logic        i_icmp_valid = 1'b0;
  logic        o_icmp_grant;
  logic        i_udp_req = 1'b0;
  logic [15:0] i_udp_len = '0;
  logic [7:0]  i_udp_data = '0;
  logic        i_udp_last = 1'b0;
  logic        i_udp_valid = 1'b0;
  logic        o_udp_grant;
  logic        i_ip_busy = 1'b0;
  logic [15:0] o_ip_len;
  logic [7:0]  o_ip_proto;
  logic [7:0]  o_ip_data;
  logic        o_ip_last;
  logic        o_ip_valid;
  logic        o_timeout;

  int nvec = 0;
  int nerr = 0;

  ip_tx_arbiter #(.GAP_CYCLES(12), .TIMEOUT(16)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_icmp_req(i_icmp_req), .i_icmp_len(i_icmp_len), .i_icmp_data(i_icmp_data),
    .i_icmp_last(i_icmp_last), .i_icmp_valid(i_icmp_valid), .o_icmp_grant(o_icmp_grant),
    .i_udp_req(i_udp_req), .i_udp_len(i_udp_len), .i_udp_data(i_udp_data),
    .i_udp_last(i_udp_last), .i_udp_valid(i_udp_valid), .o_udp_grant(o_udp_grant),
    .i_ip_busy(i_ip_busy), .o_ip_len(o_ip_len), .o_ip_proto(o_ip_proto),
    .o_ip_data(o_ip_data), .o_ip_last(o_ip_last), .o_ip_valid(o_ip_valid),
    .o_timeout(o_timeout)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Steps until either grant is seen; returns the number of edges taken (60 if none)
  task automatic wait_grant(output int n);
    n = 60;
    for (int k = 0; k < 60; k++) begin
      step();
      if (o_icmp_grant || o_udp_grant) begin
        n = k + 1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    i_rst = 1'b0;
    step();
    step();
    i_rst = 1'b1;
  endtask

  initial begin
    int n;
    int seen;

    // ---------------- reset state ----------------
    step();
    chk("rst_grants", {30'd0, o_icmp_grant, o_udp_grant}, 32'd0);
    chk("rst_len_proto", {o_ip_len, o_ip_proto, 8'd0}, 32'd0);
    chk("rst_strobes", {29'd0, o_ip_valid, o_ip_last, o_timeout}, 32'd0);
    i_rst = 1'b1;

    // ---------------- ICMP only, 40 bytes ----------------
    i_icmp_req = 1'b1;
    i_icmp_len = 16'd40;
    step();
    chk("t1_icmp_grant", {31'd0, o_icmp_grant}, 32'd1);
    chk("t1_udp_grant", {31'd0, o_udp_grant}, 32'd0);
    chk("t1_proto", {24'd0, o_ip_proto}, 32'd1);
    chk("t1_len", {16'd0, o_ip_len}, 32'd40);
    i_icmp_req = 1'b0;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      i_icmp_valid = 1'b1;
      i_icmp_data  = 8'(k + 1);
      i_icmp_last  = (k == 39);
      step();
      if (o_ip_valid && o_ip_data == 8'(k + 1) && o_ip_last == (k == 39)) seen++;
    end
    i_icmp_valid = 1'b0;
    i_icmp_last  = 1'b0;
    chk("t1_bytes_ok", seen, 32'd40);
    chk("t1_last_out", {30'd0, o_ip_valid, o_ip_last}, 32'd3);
    chk("t1_grant_drop", {31'd0, o_icmp_grant}, 32'd0);
    step();
    chk("t1_len_hold", {16'd0, o_ip_len}, 32'd40);
    chk("t1_valid_quiet", {31'd0, o_ip_valid}, 32'd0);

    // ---------------- simultaneous requests ----------------
    do_reset();
    i_icmp_req = 1'b1; i_icmp_len = 16'd3;
    i_udp_req  = 1'b1; i_udp_len  = 16'd2;
    step();
    chk("t2_icmp_first", {30'd0, o_icmp_grant, o_udp_grant}, 32'd2);
    chk("t2_len_icmp", {16'd0, o_ip_len}, 32'd3);
    i_icmp_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      i_icmp_valid = 1'b1; i_icmp_data = 8'(8'h50 + k); i_icmp_last = (k == 2);
      step();
    end
    i_icmp_valid = 1'b0; i_icmp_last = 1'b0;
    chk("t2_icmp_end", {22'd0, o_ip_data, o_ip_last, o_icmp_grant}, {22'd0, 8'h52, 1'b1, 1'b0});
    wait_grant(n);
    chk("t2_udp_gap", n, 32'd13);
    chk("t2_udp_grant", {30'd0, o_icmp_grant, o_udp_grant}, 32'd1);
    chk("t2_udp_proto_len", {o_ip_len, o_ip_proto, 8'd0}, {16'd2, 8'd17, 8'd0});
    i_udp_req  = 1'b0;
    i_icmp_req = 1'b1;
    for (int k = 0; k < 2; k++) begin
      i_udp_valid = 1'b1; i_udp_data = 8'(8'h60 + k); i_udp_last = (k == 1);
      step();
    end
    i_udp_valid = 1'b0; i_udp_last = 1'b0;
    i_udp_req   = 1'b1;
    wait_grant(n);
    chk("t2_second_gap", n, 32'd13);
    chk("t2_icmp_again", {30'd0, o_icmp_grant, o_udp_grant}, 32'd2);
    i_icmp_req = 1'b0; i_udp_req = 1'b0;
    // 1-byte frame: valid & last on the first granted cycle
    i_icmp_valid = 1'b1; i_icmp_data = 8'h77; i_icmp_last = 1'b1;
    step();
    i_icmp_valid = 1'b0; i_icmp_last = 1'b0;
    chk("t2_one_byte", {21'd0, o_ip_data, o_ip_valid, o_ip_last, o_icmp_grant}, {21'd0, 8'h77, 3'b110});

    // ---------------- busy holds off selection ----------------
    do_reset();
    i_ip_busy = 1'b1;
    i_udp_req = 1'b1; i_udp_len = 16'd5;
    seen = 0;
    repeat (20) begin
      step();
      if (o_udp_grant || o_icmp_grant) seen++;
    end
    chk("t3_no_grant_busy", seen, 32'd0);
    i_ip_busy = 1'b0;
    step();
    chk("t3_grant_after_busy", {30'd0, o_icmp_grant, o_udp_grant}, 32'd1);
    chk("t3_proto", {24'd0, o_ip_proto}, 32'd17);
    i_udp_req = 1'b0;

    // ---------------- watchdog abort ----------------
    for (int k = 0; k < 5; k++) begin
      i_udp_valid = 1'b1; i_udp_data = 8'(8'h30 + k);
      step();
    end
    i_udp_valid = 1'b0;
    n = 40;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (o_ip_valid || o_ip_last) seen++;
      if (o_timeout) begin
        n = k + 1;
        break;
      end
    end
    chk("t4_timeout_delay", n, 32'd16);
    chk("t4_no_fwd_in_stall", seen, 32'd0);
    chk("t4_abort_outs", {29'd0, o_udp_grant, o_ip_last, o_timeout}, 32'd1);
    i_icmp_req = 1'b1; i_icmp_len = 16'd1;
    step();
    chk("t4_pulse_one", {29'd0, o_timeout, o_icmp_grant, o_udp_grant}, 32'd0);
    wait_grant(n);
    chk("t4_after_gap", n, 32'd12);
    chk("t4_icmp_grant", {30'd0, o_icmp_grant, o_udp_grant}, 32'd2);
    i_icmp_req = 1'b0;
    i_icmp_valid = 1'b1; i_icmp_data = 8'h01; i_icmp_last = 1'b1;
    step();
    i_icmp_valid = 1'b0; i_icmp_last = 1'b0;

    // ---------------- non-selected source is dropped ----------------
    i_udp_req = 1'b1; i_udp_len = 16'd6;
    wait_grant(n);
    chk("t5_gap", n, 32'd13);
    chk("t5_udp_grant", {30'd0, o_icmp_grant, o_udp_grant}, 32'd1);
    i_udp_req = 1'b0;
    seen = 0;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      i_udp_valid  = (k < 6);
      i_udp_data   = 8'(8'h10 + k);
      i_udp_last   = (k == 5);
      i_icmp_valid = (k % 2 == 0);
      i_icmp_data  = 8'hAA;
      i_icmp_last  = (k == 2);
      step();
      if (o_ip_valid && o_ip_data == 8'hAA) seen++;
      if (k < 6 && o_ip_valid && o_ip_data == 8'(8'h10 + k) && o_ip_last == (k == 5)) n++;
      if (k >= 6 && o_ip_valid) seen++;
    end
    i_udp_valid = 1'b0; i_udp_last = 1'b0;
    i_icmp_valid = 1'b0; i_icmp_last = 1'b0;
    chk("t5_no_aa", seen, 32'd0);
    chk("t5_udp_intact", n, 32'd6);

    // ---------------- async reset mid-transfer ----------------
    i_icmp_req = 1'b1; i_icmp_len = 16'd20;
    wait_grant(n);
    chk("t6_icmp_grant", {30'd0, o_icmp_grant, o_udp_grant}, 32'd2);
    i_icmp_req = 1'b0;
    for (int k = 0; k < 10; k++) begin
      i_icmp_valid = 1'b1; i_icmp_data = 8'(8'h80 + k);
      step();
    end
    chk("t6_byte10", {24'd0, o_ip_data}, 32'h89);
    i_rst = 1'b0;
    i_icmp_valid = 1'b0;
    i_icmp_req = 1'b1; i_icmp_len = 16'd1;
    i_udp_req  = 1'b1; i_udp_len  = 16'd9;
    #1;
    chk("t6_rst_ctl", {27'd0, o_icmp_grant, o_udp_grant, o_ip_valid, o_ip_last, o_timeout}, 32'd0);
    chk("t6_rst_data", {o_ip_len, o_ip_proto, o_ip_data}, 32'd0);
    step();
    step();
    i_rst = 1'b1;
    step();
    chk("t6_ptr_reset", {30'd0, o_icmp_grant, o_udp_grant}, 32'd2);
    i_icmp_req = 1'b0;
    i_icmp_valid = 1'b1; i_icmp_data = 8'h05; i_icmp_last = 1'b1;
    step();
    i_icmp_valid = 1'b0; i_icmp_last = 1'b0;
    wait_grant(n);
    chk("t6_udp_gap", n, 32'd13);
    chk("t6_udp_served", {o_udp_grant, o_icmp_grant, o_ip_len, o_ip_proto, 6'd0}, {1'b1, 1'b0, 16'd9, 8'd17, 6'd0});
    i_udp_req = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/ip_tx_arbiter.md
Name: ip_tx_arbiter

Overview:
- Shares the single IP-layer transmit path between two frame sources: the ICMP reply generator and the UDP transmitter.
- Each source requests the path, is granted it, then streams one frame.
- The arbiter forwards the frame with a registered stage and tags it with the IP protocol number.
- Enforces round-robin fairness, a minimum inter-frame gap and a stall watchdog; sits between the protocol engines and the IP header builder.

Parameters:
- GAP_CYCLES, 12, idle cycles enforced after every frame end or abort; 0 means none.
- TIMEOUT, 4096, consecutive granted cycles with no source valid before abort; must be ≥ 2.
- PROTO_ICMP, 8'd1, protocol tag emitted for ICMP frames.
- PROTO_UDP, 8'd17, protocol tag emitted for UDP frames.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  asynchronous, active-low reset
- i_icmp_req  in  1  ICMP frame pending; level
- i_icmp_len  in  16  ICMP payload length in bytes; valid while req high
- i_icmp_data  in  8  ICMP byte
- i_icmp_last  in  1  final ICMP byte
- i_icmp_valid  in  1  ICMP byte strobe
- o_icmp_grant  out  1  ICMP owns the path
- i_udp_req, i_udp_len[15:0], i_udp_data[7:0], i_udp_last, i_udp_valid  in  as for ICMP
- o_udp_grant  out  1  UDP owns the path
- i_ip_busy  in  1  IP builder cannot accept a new frame
- o_ip_len  out  16  latched length of the current frame
- o_ip_proto  out  8  latched protocol of the current frame
- o_ip_data  out  8  forwarded byte
- o_ip_last  out  1  forwarded last
- o_ip_valid  out  1  forwarded strobe
- o_timeout  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset (i_rst low, asynchronous): all outputs 0, state IDLE, round-robin pointer = ICMP-first, counters 0.
- States: IDLE, XFER, GAP.
- IDLE:
  - If i_ip_busy = 0 and any req is high, select the winner.
  - Both requesting: the source indicated by the pointer wins; the pointer then flips to the other source.
  - One requesting: that source wins; the pointer is set to the other source.
  - On the selecting edge, latch len into o_ip_len and the proto tag into o_ip_proto, assert the winner's grant, and go to XFER.
  - The grant is visible the cycle after req is sampled.
  - i_ip_busy and req are sampled only in IDLE.
- XFER:
  - Selected source's data/last/valid are registered to o_ip_* with one cycle latency.
  - The non-selected source's valid is ignored; its bytes are dropped and never appear on o_ip_*.
  - On selected valid & last: grant drops on the same edge that emits o_ip_last, then go to GAP.
  - Req level during XFER is ignored.
- Watchdog:
  - Counter clears on entry to XFER and on each selected valid; otherwise it increments.
  - On reaching TIMEOUT-1: drop grant, pulse o_timeout for one cycle, go to GAP.
  - No synthetic last is emitted; the IP builder treats o_timeout as a frame abort.
- GAP:
  - Counts GAP_CYCLES cycles with all grants 0, then goes to IDLE.
  - GAP_CYCLES = 0 goes directly to IDLE on the next edge.
- Output hold: o_ip_len and o_ip_proto hold their values from grant until the next selection; they do not return to 0.
- o_ip_valid pulses only for forwarded bytes. Valid & last on the first granted cycle is a legal 1-byte frame.
- Grants are mutually exclusive and never both high.
- Minimum time from frame end to next grant: GAP_CYCLES + 1 cycles.

Test Plan:
- ICMP only: req with len=40, 40 bytes with last on byte 40 → o_icmp_grant one cycle after req; o_ip_proto=1, o_ip_len=40; 40 o_ip_valid pulses each one cycle after input; grant low after last.
- Both request simultaneously after reset → ICMP served first. UDP (proto=17) granted exactly GAP_CYCLES+1 cycles after ICMP last; a second simultaneous request → ICMP again.
- i_ip_busy high for 20 cycles with UDP req → no grant while busy; grant on the cycle after busy falls.
- Granted UDP source sends 5 bytes, then nothing; TIMEOUT=16 → o_timeout pulses 16 cycles after last valid, grant drops, no o_ip_last; next req is served after the gap.
- UDP granted while ICMP toggles valid with data 0xAA → no 0xAA on o_ip_data; UDP frame intact.
- i_rst low mid-XFER at byte 10 → all outputs 0 immediately; after release, a pending UDP req is granted with ICMP-first pointer semantics.
